// File: rtl/factorial_engine_if.sv
// Handshake/result bundle between a factorial_engine and its requester.
// The master modport is the requester and the slave modport is the engine.
interface factorial_engine_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
);
  logic             start;
  logic [IN_W-1:0]  ain;
  logic             ready;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] aout;
  logic [IN_W:0]    counter;
  logic             overflow;

  modport master (
    output start, ain,
    input  ready, busy, done, aout, counter, overflow
  );

  modport slave (
    input  start, ain,
    output ready, busy, done, aout, counter, overflow
  );
endinterface

// File: rtl/factorial_engine.sv
// Sequential N! engine: one multiply per clock, start/ready/done handshake, overflow early-stop.
// Optional macro FACTORIAL_SATURATE_EN: on overflow, aout saturates to all ones instead of holding (k-1)!.
//
// state | meaning
// IDLE  | ready for a job; results from the last job are held
// CALC  | multiplying aout by counter once per clock
// DONE  | one-cycle done pulse, then back to IDLE
module factorial_engine #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input logic              clock,
  input logic              reset,
  factorial_engine_if.slave bus
);

  localparam int P_W = OUT_W + IN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  n_q, n_d;
  logic [OUT_W-1:0] aout_q, aout_d;
  logic [IN_W:0]    counter_q, counter_d;
  logic             overflow_q, overflow_d;

  logic [P_W-1:0]   prod;
  logic             prod_fits;
  logic             calc_end;

  assign prod      = P_W'(aout_q) * P_W'(counter_q);
  assign prod_fits = (prod[P_W-1:OUT_W] == '0);
  // 1! needs no multiply, so it finishes in a single edge just like 0!.
  assign calc_end  = (counter_q > {1'b0, n_q}) || (n_q <= IN_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      aout_q     <= OUT_W'(1);
      counter_q  <= (IN_W+1)'(1);
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      aout_q     <= aout_d;
      counter_q  <= counter_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_CALC;
      ST_CALC: if (calc_end || !prod_fits) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    n_d        = n_q;
    aout_d     = aout_q;
    counter_d  = counter_q;
    overflow_d = overflow_q;
    if (state_q == ST_IDLE && bus.start) begin
      n_d        = bus.ain;
      aout_d     = OUT_W'(1);
      counter_d  = (IN_W+1)'(1);
      overflow_d = 1'b0;
    end else if (state_q == ST_CALC && !calc_end) begin
      if (prod_fits) begin
        aout_d    = prod[OUT_W-1:0];
        counter_d = counter_q + (IN_W+1)'(1);
      end else begin
        overflow_d = 1'b1;
`ifdef FACTORIAL_SATURATE_EN
        aout_d     = '1;
`else
        aout_d     = aout_q;
`endif
      end
    end
  end

  always_comb begin
    bus.ready    = (state_q == ST_IDLE);
    bus.busy     = (state_q == ST_CALC);
    bus.done     = (state_q == ST_DONE);
    bus.aout     = aout_q;
    bus.counter  = counter_q;
    bus.overflow = overflow_q;
  end

endmodule
